piso_frame_tx: RTL and testbench

- Parallel-in/serial-out framed transmitter built on a D-flip-flop shift register. It is the transmit end of the lab's serial link.
- Accepts one WIDTH-bit word through a valid/ready handshake. Shifts the word out on a single line as a frame: start bit, then WIDTH data bits, then stop bit.
- Each bit is held for DIV clock cycles.
- Sits between a parallel producer (counter, register file, test stimulus) and the SIPO receiver on the far end of the line.

---
 rtl/piso_pkg.sv | 19 +
 rtl/bit_tick_gen.sv | 37 +++
 rtl/piso_frame_tx.sv | 128 ++++++++++++
 tb/tb_piso_frame_tx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and line constants for the serial-link transmitter and receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package piso_pkg;

  // Frame sequencing states of the transmitter.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Level the line rests at between frames (also the stop-bit level).
  localparam logic LINE_IDLE = 1'b1;
  // Level of the start bit that marks the beginning of a frame.
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: one-cycle tick every DIV clocks, restartable by clear.
// Latency: first tick DIV cycles after the clear edge; tick is decoded from the counter flop.
// Backpressure: none; free-running between clears.
//
// Ports:
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset
//   clear restart the bit period on this edge
//   tick  high for one cycle at the end of each bit period
module bit_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // With DIV=1 the counter sits at 0 == LAST, so every cycle is a tick.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/piso_frame_tx.sv
// Framed PISO transmitter: start bit, WIDTH data bits, stop bit, each held DIV cycles.
// Latency: start bit on the line the edge after accept; done at accept+(WIDTH+2)*DIV.
// Backpressure: din_ready high only in IDLE; din_valid while busy is ignored, not queued.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   din, din_valid    parallel word and its valid (sampled only on the accept edge)
//   din_ready         transmitter idle and able to accept
//   sout              registered serial line, idles high
//   busy              frame in flight
//   done              one-cycle pulse when the stop bit completes
module piso_frame_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [BW-1:0]    bcnt, bcnt_n;
  logic             sout_n, busy_n, done_n, ready_n;
  logic             accept, tick;

  // Bit presented on the line is always taken from the same end of the shift register.
  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  assign accept = din_valid && din_ready;

  bit_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .tick  (tick)
  );

  always_comb begin
    state_n = state;
    sr_n    = sr;
    bcnt_n  = bcnt;
    sout_n  = sout;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        sout_n = LINE_IDLE;
        if (accept) begin
          state_n = START;
          sr_n    = din;
          bcnt_n  = '0;
          sout_n  = START_BIT;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          bcnt_n  = '0;
          sout_n  = head(sr);
        end
      end
      DATA: begin
        if (tick) begin
          if (bcnt == LAST_BIT) begin
            state_n = STOP;
            sout_n  = LINE_IDLE;
          end else begin
            sr_n   = advance(sr);
            bcnt_n = bcnt + BW'(1);
            sout_n = head(advance(sr));
          end
        end
      end
      STOP: begin
        sout_n = LINE_IDLE;
        if (tick) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        sout_n  = LINE_IDLE;
      end
    endcase
    // Status flags follow the next state so they stay registered yet aligned with it.
    busy_n  = (state_n != IDLE);
    ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      bcnt      <= '0;
      sout      <= LINE_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      din_ready <= 1'b1;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      bcnt      <= bcnt_n;
      sout      <= sout_n;
      busy      <= busy_n;
      done      <= done_n;
      din_ready <= ready_n;
    end
  end

endmodule

// File: tb/tb_piso_frame_tx.sv
// Bench for piso_frame_tx: two instances (DIV=4 MSB-first, DIV=1 LSB-first) driven
// by directed and random frames; each cycle of the line is checked against a frame
// model built from start/data/stop bit rules, and a SIPO model recovers the word.
module tb_piso_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din_a = '0, din_b = '0;
  logic       vld_a = 1'b0, vld_b = 1'b0;
  logic       rdy_a, sout_a, busy_a, done_a;
  logic       rdy_b, sout_b, busy_b, done_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  piso_frame_tx #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .din_valid(vld_a),
    .din_ready(rdy_a), .sout(sout_a), .busy(busy_a), .done(done_a)
  );

  piso_frame_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(vld_b),
    .din_ready(rdy_b), .sout(sout_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic obs(input bit sel, output logic s, output logic b, output logic d, output logic r);
    s = sel ? sout_b : sout_a;
    b = sel ? busy_b : busy_a;
    d = sel ? done_b : done_a;
    r = sel ? rdy_b  : rdy_a;
  endtask

  task automatic set_in(input bit sel, input logic [7:0] w, input logic v);
    if (sel) begin din_b = w; vld_b = v; end
    else     begin din_a = w; vld_a = v; end
  endtask

  // Expected line level k cycles after the accept edge: bit slot k/div of the frame.
  function automatic logic exp_line(input logic [7:0] w, input int div, input bit msb, input int k);
    int slot;
    slot = k / div;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return msb ? w[8 - slot] : w[slot - 1];
    return 1'b1;
  endfunction

  // Sends one frame and checks every cycle until done. swap_at>=0 keeps din_valid
  // high and changes din mid-frame; rst_at>=0 pulls reset mid-frame; chain leaves
  // the next word presented with valid high at the done edge.
  task automatic tx_frame(input bit sel, input logic [7:0] w, input int div, input bit msb,
                          input int swap_at, input logic [7:0] swap_w, input int rst_at,
                          input bit chain, input logic [7:0] next_w, output int e0);
    int         last;
    int         waited;
    int         slot;
    logic       s, b, d, r;
    logic       rdy_now;
    logic [7:0] rec;
    last = 10 * div;
    rec  = '0;
    e0   = -1;
    set_in(sel, w, 1'b1);
    waited = 0;
    do begin
      obs(sel, s, b, d, r);
      rdy_now = r;
      @(posedge clk); #1;
      waited++;
    end while (!rdy_now && waited < 300);
    chk("accept_wait", {31'd0, rdy_now}, 32'd1);
    if (!rdy_now) begin
      set_in(sel, 8'h00, 1'b0);
      return;
    end
    e0 = cyc;
    for (int k = 0; k <= last; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      obs(sel, s, b, d, r);
      chk("sout",  {31'd0, s}, {31'd0, exp_line(w, div, msb, k)});
      chk("busy",  {31'd0, b}, {31'd0, (k < last)});
      chk("done",  {31'd0, d}, {31'd0, (k == last)});
      chk("ready", {31'd0, r}, {31'd0, (k == last)});
      if (k >= div && k < 9 * div && (k % div) == div / 2) begin
        slot = k / div;
        if (msb) rec[8 - slot] = s;
        else     rec[slot - 1] = s;
      end
      if (k == 0 && swap_at < 0) set_in(sel, w, 1'b0);
      if (k == swap_at) set_in(sel, swap_w, 1'b1);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        obs(sel, s, b, d, r);
        chk("rst_sout",  {31'd0, s}, 32'd1);
        chk("rst_busy",  {31'd0, b}, 32'd0);
        chk("rst_done",  {31'd0, d}, 32'd0);
        chk("rst_ready", {31'd0, r}, 32'd1);
        repeat (3) begin
          @(posedge clk); #1;
          obs(sel, s, b, d, r);
          chk("rst_hold_sout", {31'd0, s}, 32'd1);
          chk("rst_hold_done", {31'd0, d}, 32'd0);
        end
        set_in(sel, 8'h00, 1'b0);
        rst_n = 1'b1;
        return;
      end
      if (k == last) begin
        if (chain) set_in(sel, next_w, 1'b1);
        else       set_in(sel, 8'h00, 1'b0);
      end
    end
    chk("sipo_word", {24'd0, rec}, {24'd0, w});
  endtask

  initial begin
    int         e1, e2, ed;
    bit         sel;
    logic [7:0] w;

    // Reset held with valid asserted: nothing may be accepted.
    rst_n = 1'b0;
    set_in(1'b0, 8'h77, 1'b1);
    set_in(1'b1, 8'h77, 1'b1);
    #2;
    repeat (3) begin
      @(posedge clk); #1;
      chk("reset_sout_a",  {31'd0, sout_a}, 32'd1);
      chk("reset_busy_a",  {31'd0, busy_a}, 32'd0);
      chk("reset_done_a",  {31'd0, done_a}, 32'd0);
      chk("reset_ready_a", {31'd0, rdy_a},  32'd1);
      chk("reset_sout_b",  {31'd0, sout_b}, 32'd1);
      chk("reset_busy_b",  {31'd0, busy_b}, 32'd0);
    end
    set_in(1'b0, 8'h00, 1'b0);
    set_in(1'b1, 8'h00, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_sout_a", {31'd0, sout_a}, 32'd1);
    chk("idle_busy_a", {31'd0, busy_a}, 32'd0);

    // Basic MSB-first frame, DIV=4.
    tx_frame(1'b0, 8'hA5, 4, 1'b1, -1, 8'h00, -1, 1'b0, 8'h00, ed);
    // LSB-first frame, DIV=1.
    tx_frame(1'b1, 8'h01, 1, 1'b0, -1, 8'h00, -1, 1'b0, 8'h00, ed);

    // Back-to-back with valid held high: single idle-high cycle between frames.
    repeat (3) @(posedge clk);
    #1;
    tx_frame(1'b0, 8'hFF, 4, 1'b1, 0, 8'hFF, -1, 1'b1, 8'h00, e1);
    tx_frame(1'b0, 8'h00, 4, 1'b1, -1, 8'h00, -1, 1'b0, 8'h00, e2);
    chk("b2b_accept_gap", e2 - e1, 32'd41);

    // din changes while busy must not disturb the frame in flight.
    repeat (2) @(posedge clk);
    #1;
    tx_frame(1'b0, 8'hC3, 4, 1'b1, 12, 8'h3C, -1, 1'b0, 8'h00, ed);

    // Reset mid-frame, then a clean frame afterwards.
    repeat (2) @(posedge clk);
    #1;
    tx_frame(1'b0, 8'h81, 4, 1'b1, -1, 8'h00, 17, 1'b0, 8'h00, ed);
    @(posedge clk); #1;
    tx_frame(1'b0, 8'h5A, 4, 1'b1, -1, 8'h00, -1, 1'b0, 8'h00, ed);

    // Random words on both instances, random idle gaps.
    for (int i = 0; i < 12; i++) begin
      sel = 1'($urandom_range(0, 1));
      w   = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      if (sel) tx_frame(1'b1, w, 1, 1'b0, -1, 8'h00, -1, 1'b0, 8'h00, ed);
      else     tx_frame(1'b0, w, 4, 1'b1, -1, 8'h00, -1, 1'b0, 8'h00, ed);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
